// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory sequencer with RMW for SB/SH and load extension.
// Optional DMEM_CTRL_MISALIGN_TRAP_EN flags misaligned accesses instead of issuing them.
module dmem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        stall_o,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_wen_o,
    output logic        dmem_data_oe_o,
    output logic [31:0] dmem_data_out_o,
    input  logic [31:0] dmem_data_in_i
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state_q, state_d;
    logic        wen_q, wen_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_byte, req_half, req_word, mis_req;
    logic        q_byte, q_half, active, busy;
    logic [4:0]  sh;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] wr_word, wr_b, wr_h, ld_word;

    // Store codes 100/101 are undefined and fall back to word width.
    function automatic logic is_byte(input logic w, input logic [2:0] f);
        return f[1:0] == 2'b00 && !(w && f[2]);
    endfunction
    function automatic logic is_half(input logic w, input logic [2:0] f);
        return f[1:0] == 2'b01 && !(w && f[2]);
    endfunction

    assign req_byte = is_byte(req_wen_i, req_funct3_i);
    assign req_half = is_half(req_wen_i, req_funct3_i);
    assign req_word = !req_byte && !req_half;
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
    assign mis_req = req_half ? req_addr_i[0] : (req_word && req_addr_i[1:0] != 2'b00);
`else
    assign mis_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                wen_d   = req_wen_i;
                f3_d    = req_funct3_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                err_d   = mis_req;
                cnt_d   = 4'd0;
                state_d = mis_req ? RESP : (req_wen_i && req_word) ? WR : RD;
            end
            RD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(WAIT_CYCLES)) begin
                    rbuf_d  = dmem_data_in_i;
                    state_d = wen_q ? WR : RESP;
                end
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign q_byte = is_byte(wen_q, f3_q);
    assign q_half = is_half(wen_q, f3_q);
    assign sh     = {addr_q[1:0], 3'b000};

    always_comb begin
        wr_b = rbuf_q;
        wr_b[sh +: 8] = wdata_q[7:0];
        wr_h = addr_q[1] ? {wdata_q[15:0], rbuf_q[15:0]} : {rbuf_q[31:16], wdata_q[15:0]};
    end

    assign wr_word = q_byte ? wr_b : q_half ? wr_h : wdata_q;
    assign ld_b    = rbuf_q[sh +: 8];
    assign ld_h    = addr_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
    assign ld_word = q_byte ? {{24{ld_b[7] & ~f3_q[2]}}, ld_b}
                   : q_half ? {{16{ld_h[15] & ~f3_q[2]}}, ld_h} : rbuf_q;

    // Outputs decode from registered state, forced low while reset is held.
    assign active          = !rst;
    assign busy            = active && (state_q == RD || state_q == WR);
    assign req_ready_o     = active && state_q == IDLE;
    assign stall_o         = busy;
    assign dmem_addr_o     = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wen_o      = active && state_q == WR;
    assign dmem_data_oe_o  = dmem_wen_o;
    assign dmem_data_out_o = dmem_wen_o ? wr_word : 32'd0;
    assign rsp_valid_o     = active && state_q == RESP;
    assign rsp_err_o       = rsp_valid_o && err_q;
    assign rsp_rdata_o     = (rsp_valid_o && !wen_q && !err_q) ? ld_word : 32'd0;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed checks of the data-memory sequencer.
module tb_dmem_access_ctrl;
    logic        clk = 0, rst = 1;
    logic        rv = 0, rv3 = 0, wen = 0;
    logic [2:0]  f3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        ready, rsp_v, rsp_e, stall, dwen, doe;
    logic [31:0] rdata, daddr, dout;
    logic        ready3, rsp_v3, rsp_e3, stall3, dwen3, doe3;
    logic [31:0] rdata3, daddr3, dout3;
    logic [31:0] mem [0:255];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl u_dut (
        .clk(clk), .rst(rst), .req_valid_i(rv), .req_ready_o(ready), .req_wen_i(wen),
        .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata), .rsp_valid_o(rsp_v),
        .rsp_rdata_o(rdata), .rsp_err_o(rsp_e), .stall_o(stall), .dmem_addr_o(daddr),
        .dmem_wen_o(dwen), .dmem_data_oe_o(doe), .dmem_data_out_o(dout),
        .dmem_data_in_i(mem[daddr[9:2]])
    );

    dmem_access_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid_i(rv3), .req_ready_o(ready3), .req_wen_i(wen),
        .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata), .rsp_valid_o(rsp_v3),
        .rsp_rdata_o(rdata3), .rsp_err_o(rsp_e3), .stall_o(stall3), .dmem_addr_o(daddr3),
        .dmem_wen_o(dwen3), .dmem_data_oe_o(doe3), .dmem_data_out_o(dout3),
        .dmem_data_in_i(mem[daddr3[9:2]])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input logic which, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = w; f3 = f; addr = a; wdata = d;
        if (which) rv3 = 1; else rv = 1;
        @(posedge clk);
        #1 rv = 0; rv3 = 0;
        @(negedge clk);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] exp);
        issue(0, 0, f, a, 0);
        check({tag, "_rd_addr"}, daddr, {a[31:2], 2'b00});
        @(negedge clk);
        check({tag, "_rsp"}, {rsp_v, rsp_e, stall}, {1'b1, 1'b0, 1'b0});
        check({tag, "_rdata"}, rdata, exp);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {ready, rsp_v, rsp_e, stall, dwen, doe}, 0);
        check("rst_buses", daddr | dout | rdata, 0);
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", ready, 1);

        mem[8'h40] = 32'hDEADBEEF;
        issue(0, 0, 3'b010, 32'h100, 0);
        check("lw_rd", {stall, dwen, doe, ready, rsp_v}, 5'b10000);
        check("lw_addr", daddr, 32'h100);
        @(negedge clk);
        check("lw_rsp", {rsp_v, stall, ready}, 3'b100);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("lw_idle", {ready, rsp_v}, 2'b10);

        mem[8'h40] = 32'h80FF0000;
        load_chk("lb", 3'b000, 32'h103, 32'hFFFFFF80);
        load_chk("lbu", 3'b100, 32'h103, 32'h00000080);
        load_chk("lh", 3'b001, 32'h102, 32'hFFFF80FF);
        load_chk("lhu", 3'b101, 32'h102, 32'h000080FF);
        load_chk("lb0", 3'b000, 32'h102, 32'hFFFFFFFF);
        mem[8'h40] = 32'hDEADBEEF;
        load_chk("f3_011", 3'b011, 32'h100, 32'hDEADBEEF);

        mem[8'h40] = 32'h11223344;
        issue(0, 1, 3'b000, 32'h101, 32'h000000AB);
        check("sb_rd", {stall, dwen, doe}, 3'b100);
        check("sb_rd_addr", daddr, 32'h100);
        @(negedge clk);
        check("sb_wr", {stall, dwen, doe, rsp_v}, 4'b1110);
        check("sb_wr_addr", daddr, 32'h100);
        check("sb_wr_data", dout, 32'h1122AB44);
        @(negedge clk);
        check("sb_rsp", {rsp_v, dwen, rsp_e}, 3'b100);
        check("sb_rsp_rdata", rdata, 0);
        @(negedge clk);

        issue(0, 1, 3'b001, 32'h102, 32'hFFFF5566);
        @(negedge clk);
        check("sh_wr_data", dout, 32'h55663344);
        @(negedge clk);
        check("sh_rsp", rsp_v, 1);
        @(negedge clk);

        issue(0, 1, 3'b010, 32'h200, 32'hCAFEF00D);
        check("sw_wr", {stall, dwen, doe}, 3'b111);
        check("sw_wr_addr", daddr, 32'h200);
        check("sw_wr_data", dout, 32'hCAFEF00D);
        @(negedge clk);
        check("sw_rsp", {rsp_v, dwen}, 2'b10);
        @(negedge clk);

        mem[8'h80] = 32'h12345678;
        issue(0, 1, 3'b001, 32'h202, 32'h9999);
        check("rst_mid_rd", stall, 1);
        rst = 1;
        @(negedge clk);
        check("rst_mid_outs", {dwen, rsp_v, ready, stall}, 0);
        rst = 0;
        @(negedge clk);
        check("rst_mid_after", {dwen, rsp_v, ready}, 3'b001);
        @(negedge clk);
        check("rst_mid_after2", {dwen, rsp_v}, 0);

        mem[8'h40] = 32'hDEADBEEF;
        issue(0, 0, 3'b010, 32'h102, 0);
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
        check("mis_trap", {rsp_v, rsp_e, stall, dwen}, 4'b1100);
        check("mis_trap_data", rdata | daddr, 0);
        @(negedge clk);
`else
        check("mis_rd_addr", daddr, 32'h100);
        @(negedge clk);
        check("mis_rsp", {rsp_v, rsp_e}, 2'b10);
        check("mis_rdata", rdata, 32'hDEADBEEF);
`endif
        @(negedge clk);

        issue(1, 0, 3'b010, 32'h100, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w3_rd%0d", i), {stall3, rsp_v3, daddr3}, {2'b10, 32'h100});
            @(negedge clk);
        end
        check("w3_rsp", {rsp_v3, stall3}, 2'b10);
        check("w3_rdata", rdata3, 32'hDEADBEEF);
        check("w3_main_idle", {ready, stall}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
